// File: rtl/flash_sample_sequencer.sv
// Flash sample sequencer: fetches one 32-bit word (two 16-bit samples) per
// flash read and plays the high bytes of both samples out on sample ticks,
// stepping the word address forward or backward with wrap and restart.
module flash_sample_sequencer #(
   parameter int unsigned       ADDR_W    = 23,
   parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              forward,
   input  logic              pause,
   input  logic              restart,
   input  logic              sample_tick,
   output logic              flash_read,
   output logic [ADDR_W-1:0] flash_address,
   input  logic              flash_waitrequest,
   input  logic              flash_readdatavalid,
   input  logic [31:0]       flash_readdata,
   output logic [7:0]        audio_data,
   output logic              audio_valid
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      PLAY_FIRST,
      PLAY_SECOND
   } state_t;

   state_t            state;
   logic              pending_tick;
   logic              restart_pending;
   logic [7:0]        first_byte;
   logic [7:0]        second_byte;
   logic              in_play;
   logic              eff_tick;
   logic              advance;
   logic [ADDR_W-1:0] next_addr;

   // Effective tick qualification and the address the next advance will load.
   // A restart pulse arriving on the advance cycle itself also wins.
   always_comb begin
      in_play  = (state == PLAY_FIRST) || (state == PLAY_SECOND);
      eff_tick = in_play && !pause && (sample_tick || pending_tick);
      advance  = eff_tick && (state == PLAY_SECOND);
      if (restart || restart_pending) begin
         next_addr = forward ? '0 : LAST_ADDR;
      end else if (forward) begin
         next_addr = (flash_address == LAST_ADDR) ? '0 : flash_address + ADDR_W'(1);
      end else begin
         next_addr = (flash_address == '0) ? LAST_ADDR : flash_address - ADDR_W'(1);
      end
   end

   // Sequencer FSM with registered flash request and audio outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         flash_read      <= 1'b0;
         flash_address   <= '0;
         audio_data      <= '0;
         audio_valid     <= 1'b0;
         pending_tick    <= 1'b0;
         restart_pending <= 1'b0;
         first_byte      <= '0;
         second_byte     <= '0;
      end else begin
         audio_valid <= 1'b0;

         if (advance) begin
            restart_pending <= 1'b0;
         end else if (restart) begin
            restart_pending <= 1'b1;
         end

         if (eff_tick) begin
            pending_tick <= 1'b0;
         end else if (sample_tick && !pause && !in_play) begin
            pending_tick <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (!pause) begin
                  state      <= REQ;
                  flash_read <= 1'b1;
               end
            end
            REQ: begin
               if (!flash_waitrequest) begin
                  state      <= WAIT_DATA;
                  flash_read <= 1'b0;
               end
            end
            WAIT_DATA: begin
               if (flash_readdatavalid) begin
                  first_byte  <= forward ? flash_readdata[15:8]  : flash_readdata[31:24];
                  second_byte <= forward ? flash_readdata[31:24] : flash_readdata[15:8];
                  state       <= PLAY_FIRST;
               end
            end
            PLAY_FIRST: begin
               if (eff_tick) begin
                  audio_data  <= first_byte;
                  audio_valid <= 1'b1;
                  state       <= PLAY_SECOND;
               end
            end
            PLAY_SECOND: begin
               if (eff_tick) begin
                  audio_data    <= second_byte;
                  audio_valid   <= 1'b1;
                  flash_address <= next_addr;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
